// File: rtl/ssp_rx_logic.sv
// ---------------------------------------------------------------------------
// ssp_rx_logic
// Receive side of a TI-SSI synchronous serial port. The external serial clock,
// frame sync and data are synchronized into the PCLK domain. Each rising edge
// of the synchronized serial clock is one sample event. Bits are assembled MSB
// first into an 8-bit word, which is then offered to a downstream receive FIFO.
//
// Ports
//   PCLK        in   system clock, rising edge
//   CLEAR_B     in   synchronous active-low reset
//   SSPCLKIN    in   serial clock from the external master (async, <= PCLK/4)
//   SSPFSSIN    in   frame sync, high during the bit before the MSB
//   SSPRXD      in   serial data, MSB first
//   RxFIFO_FULL in   receive FIFO full flag
//   ROR_CLR     in   one-cycle pulse that clears the overrun flag
//   RxDATA      out  last assembled word, held until the next word
//   RxFIFO_WR   out  one-cycle FIFO write strobe
//   SSPRORINTR  out  sticky receive overrun flag
//   RX_BUSY     out  high while a frame is in progress
// ---------------------------------------------------------------------------
// state   | meaning
// IDLE    | waiting for a sample event with frame sync high
// SHIFT   | collecting the 8 data bits
// DELIVER | one cycle: offer the word to the FIFO or flag an overrun
// ---------------------------------------------------------------------------
module ssp_rx_logic #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  PCLK,
    input  logic                  CLEAR_B,
    input  logic                  SSPCLKIN,
    input  logic                  SSPFSSIN,
    input  logic                  SSPRXD,
    input  logic                  RxFIFO_FULL,
    input  logic                  ROR_CLR,
    output logic [DATA_WIDTH-1:0] RxDATA,
    output logic                  RxFIFO_WR,
    output logic                  SSPRORINTR,
    output logic                  RX_BUSY
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    // Bit 2 = serial clock, bit 1 = frame sync, bit 0 = data.
    logic [2:0]            r_sync [SYNC_STAGES];
    logic                  r_clk_prev;
    state_t                r_state;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_start_pend;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_wr;
    logic                  r_ror;
    logic                  r_busy;

    logic                  w_clk_s;
    logic                  w_fss_s;
    logic                  w_rxd_s;
    logic                  w_sample;
    logic                  w_last_bit;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic                  w_pend_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_wr_nxt;
    logic                  w_ror_nxt;
    logic                  w_busy_nxt;

    // All three serial inputs share the same synchronizer depth, so data and
    // frame sync stay aligned with the serial clock edge that samples them.
    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 3'b000;
            end
            r_clk_prev <= 1'b0;
        end else begin
            r_sync[0] <= {SSPCLKIN, SSPFSSIN, SSPRXD};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_clk_prev <= w_clk_s;
        end
    end

    assign w_clk_s    = r_sync[SYNC_STAGES-1][2];
    assign w_fss_s    = r_sync[SYNC_STAGES-1][1];
    assign w_rxd_s    = r_sync[SYNC_STAGES-1][0];
    assign w_sample   = w_clk_s & ~r_clk_prev;
    assign w_last_bit = (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));

    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_sample && w_fss_s) w_state_nxt = SHIFT;
            SHIFT:   if (w_sample && w_last_bit) w_state_nxt = DELIVER;
            DELIVER: w_state_nxt = r_start_pend ? SHIFT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_pend_nxt  = r_start_pend;
        w_data_nxt  = r_data;
        w_wr_nxt    = 1'b0;
        // Clear first; a same-cycle overrun below overrides it.
        w_ror_nxt   = r_ror & ~ROR_CLR;
        w_busy_nxt  = (w_state_nxt != IDLE);
        unique case (r_state)
            IDLE: begin
                if (w_sample && w_fss_s) w_cnt_nxt = '0;
            end
            SHIFT: begin
                if (w_sample) begin
                    w_shift_nxt = {r_shift[DATA_WIDTH-2:0], w_rxd_s};
                    w_cnt_nxt   = r_bit_cnt + CNT_W'(1);
                    if (w_last_bit) begin
                        w_data_nxt = {r_shift[DATA_WIDTH-2:0], w_rxd_s};
                        // Frame sync on the LSB starts the next frame back-to-back.
                        w_pend_nxt = w_fss_s;
                    end
                end
            end
            DELIVER: begin
                if (RxFIFO_FULL) w_ror_nxt = 1'b1;
                else             w_wr_nxt  = 1'b1;
                if (r_start_pend) begin
                    w_cnt_nxt  = '0;
                    w_pend_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!CLEAR_B) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_start_pend <= 1'b0;
            r_data       <= '0;
            r_wr         <= 1'b0;
            r_ror        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_bit_cnt    <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_start_pend <= w_pend_nxt;
            r_data       <= w_data_nxt;
            r_wr         <= w_wr_nxt;
            r_ror        <= w_ror_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign RxDATA     = r_data;
    assign RxFIFO_WR  = r_wr;
    assign SSPRORINTR = r_ror;
    assign RX_BUSY    = r_busy;

endmodule

// File: tb/tb_ssp_rx_logic.sv
// ---------------------------------------------------------------------------
// tb_ssp_rx_logic
// Drives serial frames into ssp_rx_logic and compares every output on every
// PCLK cycle against a frame-level reference model. The model works per serial
// clock rising edge and turns each completed word into timed expectations:
// an input edge driven after PCLK edge k is seen as a sample event in the cycle
// after edge k+2, so the word appears on RxDATA after edge k+3 and the write
// strobe or overrun after edge k+4.
// ---------------------------------------------------------------------------
module tb_ssp_rx_logic;

    localparam int NCYC = 30000;

    logic       PCLK        = 1'b0;
    logic       CLEAR_B     = 1'b0;
    logic       SSPCLKIN    = 1'b0;
    logic       SSPFSSIN    = 1'b0;
    logic       SSPRXD      = 1'b0;
    logic       RxFIFO_FULL = 1'b0;
    logic       ROR_CLR     = 1'b0;
    logic [7:0] RxDATA;
    logic       RxFIFO_WR;
    logic       SSPRORINTR;
    logic       RX_BUSY;

    ssp_rx_logic #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .PCLK        (PCLK),
        .CLEAR_B     (CLEAR_B),
        .SSPCLKIN    (SSPCLKIN),
        .SSPFSSIN    (SSPFSSIN),
        .SSPRXD      (SSPRXD),
        .RxFIFO_FULL (RxFIFO_FULL),
        .ROR_CLR     (ROR_CLR),
        .RxDATA      (RxDATA),
        .RxFIFO_WR   (RxFIFO_WR),
        .SSPRORINTR  (SSPRORINTR),
        .RX_BUSY     (RX_BUSY)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_k = 0;

    // Inputs as seen at each PCLK edge, and model-scheduled events per edge.
    bit         full_at [NCYC];
    bit         clr_at  [NCYC];
    bit         rst_at  [NCYC];
    bit         dv      [NCYC];
    logic [7:0] dval    [NCYC];
    bit         bv      [NCYC];
    bit         bval    [NCYC];
    bit         dlv     [NCYC];

    bit         m_in_frame = 1'b0;
    int         m_nbits    = 0;
    logic [7:0] m_word     = 8'h00;

    int         wr_cnt = 0;
    logic [7:0] wr_log [$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge PCLK) begin
        cyc = cyc + 1;
        if (cyc < NCYC) begin
            full_at[cyc] = RxFIFO_FULL;
            clr_at[cyc]  = ROR_CLR;
            rst_at[cyc]  = !CLEAR_B;
        end
    end

    task automatic model_sample(input bit f, input bit d, input int k);
        if (k + 4 >= NCYC) return;
        if (!m_in_frame) begin
            if (f) begin
                m_in_frame = 1'b1;
                m_nbits    = 0;
                bv[k+3]    = 1'b1;
                bval[k+3]  = 1'b1;
            end
        end else begin
            m_word  = {m_word[6:0], d};
            m_nbits = m_nbits + 1;
            if (m_nbits == 8) begin
                dv[k+3]   = 1'b1;
                dval[k+3] = m_word;
                dlv[k+4]  = 1'b1;
                if (f) begin
                    m_nbits = 0;
                end else begin
                    m_in_frame = 1'b0;
                    bv[k+4]    = 1'b1;
                    bval[k+4]  = 1'b0;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_nbits    = 0;
    endtask

    // Per-cycle compare against the model.
    logic [7:0] e_data = 8'h00;
    bit         e_busy = 1'b0;
    bit         e_ror  = 1'b0;
    bit         e_wr   = 1'b0;

    always @(negedge PCLK) begin
        if (cyc >= 1 && cyc < NCYC) begin
            if (rst_at[cyc]) begin
                e_data = 8'h00;
                e_busy = 1'b0;
                e_ror  = 1'b0;
                e_wr   = 1'b0;
            end else begin
                if (dv[cyc]) e_data = dval[cyc];
                if (bv[cyc]) e_busy = bval[cyc];
                e_wr = dlv[cyc] && !full_at[cyc];
                if (dlv[cyc] && full_at[cyc]) e_ror = 1'b1;
                else if (clr_at[cyc])         e_ror = 1'b0;
            end
            chk("rxdata",  RxDATA,            e_data);
            chk("wr",      {7'd0, RxFIFO_WR}, {7'd0, e_wr});
            chk("ror",     {7'd0, SSPRORINTR},{7'd0, e_ror});
            chk("busy",    {7'd0, RX_BUSY},   {7'd0, e_busy});
        end
        if (RxFIFO_WR === 1'b1) begin
            wr_cnt++;
            wr_log.push_back(RxDATA);
        end
    end

    initial begin
        #(NCYC * 10 - 100);
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "timeout");
    end

    task automatic rise(input bit f, input bit d);
        @(negedge PCLK);
        SSPCLKIN = 1'b1;
        SSPFSSIN = f;
        SSPRXD   = d;
        last_k   = cyc;
        model_sample(f, d, cyc);
    endtask

    task automatic ev(input bit f, input bit d, input int hi, input int lo);
        rise(f, d);
        repeat (hi) @(negedge PCLK);
        SSPCLKIN = 1'b0;
        SSPFSSIN = 1'($urandom);
        SSPRXD   = 1'($urandom);
        repeat (lo - 1) @(negedge PCLK);
    endtask

    task automatic ev8(input bit f, input bit d);
        ev(f, d, 4, 4);
    endtask

    task automatic send_word(input logic [7:0] w, input bit fss_last);
        for (int i = 7; i >= 0; i--) ev8((i == 0) ? fss_last : 1'b0, w[i]);
    endtask

    initial begin
        int wr0;
        logic [7:0] w;

        repeat (3) @(negedge PCLK);
        CLEAR_B = 1'b1;
        repeat (2) @(negedge PCLK);
        chk("reset_rxdata", RxDATA, 8'h00);
        chk("reset_busy",   {7'd0, RX_BUSY}, 8'h00);
        chk("reset_ror",    {7'd0, SSPRORINTR}, 8'h00);

        // Single frame 0xA5.
        wr0 = wr_cnt;
        ev8(1'b1, 1'b0);
        send_word(8'hA5, 1'b0);
        repeat (8) @(negedge PCLK);
        chk("a5_wr_count", 8'(wr_cnt - wr0), 8'd1);
        chk("a5_data",     wr_log[$], 8'hA5);
        chk("a5_ror",      {7'd0, SSPRORINTR}, 8'h00);
        chk("a5_busy",     {7'd0, RX_BUSY}, 8'h00);

        // Back-to-back 0x01, 0x02.
        wr0 = wr_cnt;
        ev8(1'b1, 1'b0);
        send_word(8'h01, 1'b1);
        send_word(8'h02, 1'b0);
        repeat (8) @(negedge PCLK);
        chk("b2b_wr_count", 8'(wr_cnt - wr0), 8'd2);
        chk("b2b_first",    wr_log[$-1], 8'h01);
        chk("b2b_second",   wr_log[$], 8'h02);

        // Overrun with 0x3C.
        wr0 = wr_cnt;
        RxFIFO_FULL = 1'b1;
        ev8(1'b1, 1'b0);
        send_word(8'h3C, 1'b0);
        repeat (8) @(negedge PCLK);
        RxFIFO_FULL = 1'b0;
        chk("ovr_wr_count", 8'(wr_cnt - wr0), 8'd0);
        chk("ovr_ror",      {7'd0, SSPRORINTR}, 8'h01);
        chk("ovr_data",     RxDATA, 8'h3C);
        repeat (10) @(negedge PCLK);
        chk("ovr_ror_sticky", {7'd0, SSPRORINTR}, 8'h01);
        ROR_CLR = 1'b1;
        @(negedge PCLK);
        ROR_CLR = 1'b0;
        @(negedge PCLK);
        chk("ovr_ror_cleared", {7'd0, SSPRORINTR}, 8'h00);

        // Reset after 4 bits, then frame 0xFF.
        wr0 = wr_cnt;
        ev8(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) ev8(1'b0, 1'b1);
        repeat (3) @(negedge PCLK);
        CLEAR_B = 1'b0;
        model_reset();
        @(negedge PCLK);
        CLEAR_B = 1'b1;
        @(negedge PCLK);
        chk("rst_mid_busy", {7'd0, RX_BUSY}, 8'h00);
        ev8(1'b1, 1'b0);
        send_word(8'hFF, 1'b0);
        repeat (8) @(negedge PCLK);
        chk("rst_mid_wr_count", 8'(wr_cnt - wr0), 8'd1);
        chk("rst_mid_data",     wr_log[$], 8'hFF);

        // 16 sample events without frame sync.
        wr0 = wr_cnt;
        for (int i = 0; i < 16; i++) ev8(1'b0, 1'($urandom));
        repeat (8) @(negedge PCLK);
        chk("nofss_wr_count", 8'(wr_cnt - wr0), 8'd0);
        chk("nofss_busy",     {7'd0, RX_BUSY}, 8'h00);
        chk("nofss_data",     RxDATA, 8'hFF);

        // Overrun and ROR_CLR in the same DELIVER cycle.
        chk("coinc_ror_before", {7'd0, SSPRORINTR}, 8'h00);
        RxFIFO_FULL = 1'b1;
        w = 8'h96;
        ev8(1'b1, 1'b0);
        for (int i = 7; i >= 1; i--) ev8(1'b0, w[i]);
        rise(1'b0, w[0]);
        repeat (2) @(negedge PCLK);
        SSPCLKIN = 1'b0;
        @(negedge PCLK);
        ROR_CLR = 1'b1;
        @(negedge PCLK);
        ROR_CLR = 1'b0;
        repeat (4) @(negedge PCLK);
        RxFIFO_FULL = 1'b0;
        chk("coinc_ror", {7'd0, SSPRORINTR}, 8'h01);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            RxFIFO_FULL = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) begin
                @(negedge PCLK);
                ROR_CLR = 1'b1;
                @(negedge PCLK);
                ROR_CLR = 1'b0;
            end
            ev(($urandom_range(0, 4) == 0), 1'($urandom),
               $urandom_range(2, 4), $urandom_range(2, 4));
        end
        repeat (12) @(negedge PCLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssp_rx_logic.md
SSP_RX_LOGIC -- requirements
Module: ssp_rx_logic

Interface
REQ-001 Parameter DATA_WIDTH, default 8, receive word width; only value 8 is supported.
REQ-002 Parameter SYNC_STAGES, default 2, flip-flop depth of each input synchronizer.
REQ-003 PCLK  input  1  system clock; all state changes on rising edge.
REQ-004 CLEAR_B  input  1  reset, synchronous, active-low.
REQ-005 SSPCLKIN  input  1  serial clock from external master, asynchronous to PCLK, frequency <= PCLK/4.
REQ-006 SSPFSSIN  input  1  frame sync (TI SSI format), high for one serial-clock period, sampled with the bit before MSB.
REQ-007 SSPRXD  input  1  serial data, MSB first.
REQ-008 RxFIFO_FULL  input  1  receive FIFO full flag from downstream FIFO.
REQ-009 ROR_CLR  input  1  one-PCLK pulse clearing the overrun flag.
REQ-010 RxDATA  output  8  assembled word presented to receive FIFO.
REQ-011 RxFIFO_WR  output  1  FIFO write strobe, one PCLK wide.
REQ-012 SSPRORINTR  output  1  receive overrun flag, sticky.
REQ-013 RX_BUSY  output  1  high while a frame is in progress.

Function
REQ-014 SSPCLKIN, SSPFSSIN, SSPRXD SHALL each pass through SYNC_STAGES flip-flops before use.
REQ-015 A sample event SHALL be one PCLK cycle where synchronized SSPCLKIN is 1 and its previous registered value is 0.
REQ-016 FSM states SHALL be IDLE, SHIFT, DELIVER; all outputs registered.
REQ-017 IDLE: sample event with synced FSS=1 -> SHIFT, bit counter cleared to 0; sample event with FSS=0 -> remain IDLE, no state change.
REQ-018 SHIFT: each sample event shifts synced SSPRXD into LSB of shift register (MSB first) and increments the 3-bit counter.
REQ-019 SHIFT: FSS SHALL be ignored on bits 1-7 (counter values 0-6 before increment).
REQ-020 On the 8th sample event in SHIFT -> DELIVER; if FSS=1 on that same sample event, a start-pending flag SHALL be set.
REQ-021 DELIVER lasts exactly one PCLK cycle; RxDATA SHALL be loaded with the 8-bit word on entry and held until the next DELIVER.
REQ-022 DELIVER with RxFIFO_FULL=0: RxFIFO_WR=1 for that cycle only.
REQ-023 DELIVER with RxFIFO_FULL=1: RxFIFO_WR stays 0, word dropped, SSPRORINTR set to 1.
REQ-024 Exit from DELIVER: start-pending=1 -> SHIFT with counter 0 and start-pending cleared; otherwise -> IDLE.
REQ-025 Latency: RxFIFO_WR SHALL assert exactly 2 PCLK cycles after the sample event of the 8th bit is detected (1 cycle DELIVER entry, 1 cycle registered strobe).
REQ-026 SSPRORINTR SHALL clear on ROR_CLR=1; if set and clear coincide, set wins.
REQ-027 RX_BUSY SHALL be 1 in SHIFT and DELIVER, 0 in IDLE.
REQ-028 No sample event occurs during DELIVER given REQ-005; back-to-back frames SHALL lose no bits.

Reset
REQ-029 CLEAR_B=0 at a PCLK edge SHALL force IDLE, counter 0, shift register 0, start-pending 0, synchronizers 0, RxDATA=0x00, RxFIFO_WR=0, SSPRORINTR=0, RX_BUSY=0.
REQ-030 Reset mid-frame SHALL discard the partial word with no FIFO write.
REQ-031 After CLEAR_B returns high, the block SHALL accept a new frame starting at the next FSS sample event.

Verification
REQ-032 SSPCLKIN period 8 PCLK, FSS pulse then bits 0xA5, FULL=0 -> one RxFIFO_WR pulse, RxDATA=0xA5, SSPRORINTR=0, RX_BUSY back to 0.
REQ-033 Frames 0x01 then 0x02, second FSS coincident with first word's LSB -> two WR pulses, RxDATA 0x01 then 0x02, RX_BUSY never low between them.
REQ-034 Frame 0x3C with FULL=1 at DELIVER -> no WR, SSPRORINTR=1 persisting; ROR_CLR pulse -> SSPRORINTR=0.
REQ-035 CLEAR_B low for 1 PCLK after 4 bits of a frame -> no WR, RX_BUSY=0; following frame 0xFF -> RxDATA=0xFF, one WR.
REQ-036 16 sample events with FSS=0 throughout -> RX_BUSY=0, no WR, RxDATA unchanged.
REQ-037 ROR_CLR asserted in the same cycle as an overrun DELIVER -> SSPRORINTR=1.
